// File: rtl/dtw_traceback.sv
// Walks the DTW path-direction matrix from (i_tlen, i_rlen) back to (0,0), streaming (i,j) points.
// Optional point counter output o_steps enabled with `define DTW_TB_STEPCNT_EN.
module dtw_traceback #(
    parameter int IDX_W  = 5,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [IDX_W-1:0]  i_tlen,
    input  logic [IDX_W-1:0]  i_rlen,
    output logic              busy,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_rd_data,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [IDX_W-1:0]  o_i,
    output logic [IDX_W-1:0]  o_j,
    output logic              o_last,
`ifdef DTW_TB_STEPCNT_EN
    output logic [IDX_W+1:0]  o_steps,
`endif
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, EMIT, READ, WAIT, FIN} state_t;

    localparam logic [IDX_W-1:0] ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] ZERO = '0;

    state_t           state, state_n;
    logic [IDX_W-1:0] i, i_n;
    logic [IDX_W-1:0] j, j_n;
    logic             err_n;
    logic             at_origin;
    logic             hs;

    assign at_origin = (i == ZERO) && (j == ZERO);
    assign hs        = (state == EMIT) && o_ready;

    // Outputs decode straight from registered state, so async reset clears them at once.
    assign busy      = (state != IDLE);
    assign o_valid   = (state == EMIT);
    assign o_i       = i;
    assign o_j       = j;
    assign o_last    = (state == EMIT) && at_origin;
    assign mem_rd_en = (state == READ);
    assign mem_addr  = (state == READ) ? {i, j} : '0;
    assign done      = (state == FIN);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            i     <= i_n;
            j     <= j_n;
            err   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        i_n     = i;
        j_n     = j;
        err_n   = err;
        case (state)
            IDLE: begin
                if (start) begin
                    i_n     = i_tlen;
                    j_n     = i_rlen;
                    err_n   = 1'b0;
                    state_n = EMIT;
                end
            end
            EMIT: begin
                // Edge row/column moves are forced, so they skip the RAM round trip.
                if (o_ready) begin
                    if (at_origin)      state_n = FIN;
                    else if (i == ZERO) j_n = j - ONE;
                    else if (j == ZERO) i_n = i - ONE;
                    else                state_n = READ;
                end
            end
            READ: state_n = WAIT;
            WAIT: begin
                case (mem_rd_data)
                    2'b11: begin
                        i_n     = i - ONE;
                        j_n     = j - ONE;
                        state_n = EMIT;
                    end
                    2'b10: begin
                        i_n     = i - ONE;
                        state_n = EMIT;
                    end
                    2'b01: begin
                        j_n     = j - ONE;
                        state_n = EMIT;
                    end
                    default: begin
                        err_n   = 1'b1;
                        state_n = FIN;
                    end
                endcase
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

`ifdef DTW_TB_STEPCNT_EN
    function automatic logic [IDX_W+1:0] sat_inc(input logic [IDX_W+1:0] v);
        return (&v) ? v : v + {{(IDX_W+1){1'b0}}, 1'b1};
    endfunction

    logic [IDX_W+1:0] steps;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)                       steps <= '0;
        else if (state == IDLE && start) steps <= '0;
        else if (hs)                     steps <= sat_inc(steps);
    end

    assign o_steps = steps;
`endif

endmodule

// File: tb/tb_dtw_traceback.sv
// Table-driven bench for dtw_traceback with a path RAM model and point/read scoreboards.
module tb_dtw_traceback;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       start = 1'b0;
    logic [4:0] i_tlen = '0;
    logic [4:0] i_rlen = '0;
    logic       busy, mem_rd_en, o_valid, o_last, done, err;
    logic [9:0] mem_addr;
    logic [1:0] mem_rd_data = 2'b00;
    logic       o_ready = 1'b0;
    logic [4:0] o_i, o_j;
`ifdef DTW_TB_STEPCNT_EN
    logic [6:0] o_steps;
`endif

    dtw_traceback #(.IDX_W(5), .ADDR_W(10)) dut (
        .clk(clk), .nrst(nrst), .start(start), .i_tlen(i_tlen), .i_rlen(i_rlen),
        .busy(busy), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_i(o_i), .o_j(o_j), .o_last(o_last),
`ifdef DTW_TB_STEPCNT_EN
        .o_steps(o_steps),
`endif
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [1:0] ram [0:1023];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_addr];

    typedef struct packed {
        logic [4:0]       tlen;
        logic [4:0]       rlen;
        logic [2:0]       nram;
        logic [2:0][9:0]  raddr;
        logic [2:0][1:0]  rcode;
        logic [2:0]       npts;
        logic [3:0][4:0]  pi;
        logic [3:0][4:0]  pj;
        logic             err;
        logic             toggle;
    } vec_t;

    vec_t vecs [7];

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    logic [10:0] pt_q [$];
    logic [9:0]  rd_q [$];
    bit          mon_en = 1'b0;
    bit          expect_done = 1'b0;
    int          vcnt = 0;
    int          rdcnt = 0;
    bit          held = 1'b0;
    logic [10:0] held_pt;

    // Monitor at the falling edge: handshakes and reads seen here complete on the next rising edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_valid) begin
                vcnt++;
                if (held) chk("hold_stable", {o_i, o_j, o_last}, held_pt);
                held = 1'b0;
                if (o_ready) begin
                    if (pt_q.size() == 0) chk("extra_point", {o_i, o_j, o_last}, -1);
                    else chk("point", {o_i, o_j, o_last}, pt_q.pop_front());
                    if (o_last) expect_done = 1'b1;
                end else begin
                    held = 1'b1;
                    held_pt = {o_i, o_j, o_last};
                end
            end
            if (mem_rd_en) begin
                rdcnt++;
                if (rd_q.size() == 0) chk("extra_read", mem_addr, -1);
                else chk("read_addr", mem_addr, rd_q.pop_front());
            end
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        bit done_seen;
        logic [4:0] pi, pj;
        for (int a = 0; a < 1024; a++) ram[a] = 2'b00;
        for (int k = 0; k < 3; k++) if (k < int'(v.nram)) begin
            ram[v.raddr[k]] = v.rcode[k];
            rd_q.push_back(v.raddr[k]);
        end
        for (int k = 0; k < 4; k++) if (k < int'(v.npts)) begin
            pi = v.pi[k];
            pj = v.pj[k];
            pt_q.push_back({pi, pj, (pi == 5'd0 && pj == 5'd0)});
        end
        vcnt = 0;
        rdcnt = 0;
        held = 1'b0;
        expect_done = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; i_tlen = v.tlen; i_rlen = v.rlen; o_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk($sformatf("v%0d_busy_after_start", idx), busy, 1);
        chk($sformatf("v%0d_err_cleared", idx), err, 0);
        done_seen = 1'b0;
        for (int c = 0; c < 200 && !done_seen; c++) begin
            if (v.toggle) o_ready = ~o_ready;
            if (v.toggle && c == 3) begin
                start = 1'b1; i_tlen = 5'd3; i_rlen = 5'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                done_seen = 1'b1;
                chk($sformatf("v%0d_done_timing", idx), int'(expect_done || v.err), 1);
            end else if (expect_done) begin
                chk($sformatf("v%0d_done_late", idx), 0, 1);
                expect_done = 1'b0;
            end
        end
        start = 1'b0;
        chk($sformatf("v%0d_done_seen", idx), done_seen, 1);
        chk($sformatf("v%0d_err", idx), err, v.err);
        chk($sformatf("v%0d_points_left", idx), pt_q.size(), 0);
        chk($sformatf("v%0d_reads", idx), rdcnt, v.nram);
        if (!v.toggle) chk($sformatf("v%0d_valid_cycles", idx), vcnt, v.npts);
`ifdef DTW_TB_STEPCNT_EN
        chk($sformatf("v%0d_steps", idx), o_steps, v.npts);
`endif
        @(posedge clk); #1;
        chk($sformatf("v%0d_done_one_cycle", idx), done, 0);
        chk($sformatf("v%0d_idle", idx), busy, 0);
        chk($sformatf("v%0d_err_sticky", idx), err, v.err);
        mon_en = 1'b0;
        pt_q.delete();
        rd_q.delete();
    endtask

    initial begin
        vecs[0] = '0; vecs[0].tlen = 2; vecs[0].rlen = 2; vecs[0].nram = 2;
        vecs[0].raddr = {10'd0, {5'd1, 5'd1}, {5'd2, 5'd2}}; vecs[0].rcode = {2'b00, 2'b11, 2'b11};
        vecs[0].npts = 3; vecs[0].pi = {5'd0, 5'd0, 5'd1, 5'd2}; vecs[0].pj = {5'd0, 5'd0, 5'd1, 5'd2};

        vecs[1] = '0; vecs[1].tlen = 3; vecs[1].rlen = 1; vecs[1].nram = 3;
        vecs[1].raddr = {{5'd1, 5'd1}, {5'd2, 5'd1}, {5'd3, 5'd1}}; vecs[1].rcode = {2'b11, 2'b10, 2'b10};
        vecs[1].npts = 4; vecs[1].pi = {5'd0, 5'd1, 5'd2, 5'd3}; vecs[1].pj = {5'd0, 5'd1, 5'd1, 5'd1};

        vecs[2] = '0; vecs[2].tlen = 0; vecs[2].rlen = 3; vecs[2].nram = 0;
        vecs[2].npts = 4; vecs[2].pi = '0; vecs[2].pj = {5'd0, 5'd1, 5'd2, 5'd3};

        vecs[3] = '0; vecs[3].tlen = 2; vecs[3].rlen = 2; vecs[3].nram = 1;
        vecs[3].raddr = {10'd0, 10'd0, {5'd2, 5'd2}}; vecs[3].rcode = '0;
        vecs[3].npts = 1; vecs[3].pi = {15'd0, 5'd2}; vecs[3].pj = {15'd0, 5'd2}; vecs[3].err = 1;

        vecs[4] = vecs[0]; vecs[4].toggle = 1;

        vecs[5] = '0; vecs[5].tlen = 1; vecs[5].rlen = 2; vecs[5].nram = 2;
        vecs[5].raddr = {10'd0, {5'd1, 5'd1}, {5'd1, 5'd2}}; vecs[5].rcode = {2'b00, 2'b10, 2'b01};
        vecs[5].npts = 4; vecs[5].pi = {5'd0, 5'd0, 5'd1, 5'd1}; vecs[5].pj = {5'd0, 5'd1, 5'd1, 5'd2};

        vecs[6] = '0; vecs[6].npts = 1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_oi_oj_last", {o_i, o_j, o_last}, 0);
        @(negedge clk);
        nrst = 1'b1;

        for (int n = 0; n < 6; n++) run_vec(vecs[n], n);

        // Abort a run while the RAM read is outstanding.
        for (int a = 0; a < 1024; a++) ram[a] = 2'b11;
        @(posedge clk); #1;
        start = 1'b1; i_tlen = 5'd2; i_rlen = 5'd2; o_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            bit seen_rd;
            seen_rd = 1'b0;
            for (int c = 0; c < 20 && !seen_rd; c++) begin
                if (mem_rd_en) seen_rd = 1'b1;
                else begin @(posedge clk); #1; end
            end
            chk("abort_reached_read", seen_rd, 1);
        end
        @(posedge clk); #1;
        nrst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", o_valid, 0);
        chk("abort_rd_en", mem_rd_en, 0);
        chk("abort_done_err", {done, err}, 0);
        begin
            int rds;
            rds = 0;
            repeat (3) begin @(posedge clk); #1; if (mem_rd_en) rds++; end
            chk("abort_no_reads", rds, 0);
        end
        @(negedge clk);
        nrst = 1'b1;
        run_vec(vecs[6], 6);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
